// File: rtl/memory_responder.sv
// Multi-channel global memory model answering the controller's four-phase read/write valid/ready protocol.
// Latency: request sampled at edge T raises ready at edge T+LATENCY; ready falls on the edge valid is seen low.
// Backpressure: one outstanding request per channel; inputs are ignored outside IDLE; side-load port never stalls.
// Ports:
//   clk, reset (async active-low)
//   mem_read_valid/address  -> mem_read_ready/data   (per channel, flattened vectors)
//   mem_write_valid/address/data -> mem_write_ready  (per channel, flattened vectors)
//   load_valid/address/data : side-load write into the array (test and boot images)
module memory_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 16,
  parameter int NUM_CHANNELS = 1,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
  input  logic [ADDR_BITS*NUM_CHANNELS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]           mem_read_ready,
  output logic [DATA_BITS*NUM_CHANNELS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
  input  logic [ADDR_BITS*NUM_CHANNELS-1:0] mem_write_address,
  input  logic [DATA_BITS*NUM_CHANNELS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_ready,
  input  logic                              load_valid,
  input  logic [ADDR_BITS-1:0]              load_address,
  input  logic [DATA_BITS-1:0]              load_data
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

  // Array contents are deliberately not reset; images arrive through the load port.
  logic [DATA_BITS-1:0] mem [DEPTH];

  logic [1:0]           state_q    [NUM_CHANNELS];
  logic [1:0]           state_d    [NUM_CHANNELS];
  logic [3:0]           cnt_q      [NUM_CHANNELS];
  logic [3:0]           cnt_d      [NUM_CHANNELS];
  logic                 kind_q     [NUM_CHANNELS];  // 1 = write, 0 = read
  logic                 kind_d     [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_q     [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_d     [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wdata_q    [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wdata_d    [NUM_CHANNELS];
  logic                 rd_ready_q [NUM_CHANNELS];
  logic                 rd_ready_d [NUM_CHANNELS];
  logic                 wr_ready_q [NUM_CHANNELS];
  logic                 wr_ready_d [NUM_CHANNELS];
  logic [DATA_BITS-1:0] rd_data_q  [NUM_CHANNELS];
  logic [DATA_BITS-1:0] rd_data_d  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] commit;

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      state_d[i]    = state_q[i];
      cnt_d[i]      = cnt_q[i];
      kind_d[i]     = kind_q[i];
      addr_d[i]     = addr_q[i];
      wdata_d[i]    = wdata_q[i];
      rd_ready_d[i] = rd_ready_q[i];
      wr_ready_d[i] = wr_ready_q[i];
      rd_data_d[i]  = rd_data_q[i];
      commit[i]     = 1'b0;
      case (state_q[i])
        ST_IDLE: begin
          // Read wins when both requests are presented together.
          if (mem_read_valid[i]) begin
            addr_d[i]  = mem_read_address[i*ADDR_BITS +: ADDR_BITS];
            kind_d[i]  = 1'b0;
            cnt_d[i]   = CNT_INIT;
            state_d[i] = ST_BUSY;
          end else if (mem_write_valid[i]) begin
            addr_d[i]  = mem_write_address[i*ADDR_BITS +: ADDR_BITS];
            wdata_d[i] = mem_write_data[i*DATA_BITS +: DATA_BITS];
            kind_d[i]  = 1'b1;
            cnt_d[i]   = CNT_INIT;
            state_d[i] = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q[i] != 4'd0) begin
            cnt_d[i] = cnt_q[i] - 4'd1;
          end else begin
            commit[i]  = 1'b1;
            state_d[i] = ST_RESPOND;
            if (kind_q[i]) begin
              wr_ready_d[i] = 1'b1;
            end else begin
              // Array writes land via NBA, so this sees the pre-edge contents.
              rd_data_d[i]  = mem[addr_q[i]];
              rd_ready_d[i] = 1'b1;
            end
          end
        end
        ST_RESPOND: begin
          if (kind_q[i] ? !mem_write_valid[i] : !mem_read_valid[i]) begin
            rd_ready_d[i] = 1'b0;
            wr_ready_d[i] = 1'b0;
            state_d[i]    = ST_IDLE;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i]    <= ST_IDLE;
        cnt_q[i]      <= 4'd0;
        kind_q[i]     <= 1'b0;
        addr_q[i]     <= '0;
        wdata_q[i]    <= '0;
        rd_ready_q[i] <= 1'b0;
        wr_ready_q[i] <= 1'b0;
        rd_data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i]    <= state_d[i];
        cnt_q[i]      <= cnt_d[i];
        kind_q[i]     <= kind_d[i];
        addr_q[i]     <= addr_d[i];
        wdata_q[i]    <= wdata_d[i];
        rd_ready_q[i] <= rd_ready_d[i];
        wr_ready_q[i] <= wr_ready_d[i];
        rd_data_q[i]  <= rd_data_d[i];
      end
    end
  end

  // Later assignments win within this block: highest channel first, then
  // down to channel 0, with the side-load last so it has top priority.
  always_ff @(posedge clk) begin
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if ((WRITE_ENABLE != 0) && commit[i] && kind_q[i]) begin
        mem[addr_q[i]] <= wdata_q[i];
      end
    end
    if (load_valid) begin
      mem[load_address] <= load_data;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      mem_read_ready[i]                       = rd_ready_q[i];
      mem_write_ready[i]                      = wr_ready_q[i];
      mem_read_data[i*DATA_BITS +: DATA_BITS] = rd_data_q[i];
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: a 2-channel writable instance (LATENCY=2)
// and a 1-channel read-only instance (LATENCY=1, WRITE_ENABLE=0).
// Inputs driven and outputs sampled on the falling edge; DUT acts on the rising edge.
module tb_memory_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 2 channels, LATENCY 2, writable
  logic        rst_a_n;
  logic [1:0]  a_rv, a_wv, a_rrdy, a_wrdy;
  logic [15:0] a_ra, a_wa;
  logic [31:0] a_wd, a_rd;
  logic        a_lv;
  logic [7:0]  a_la;
  logic [15:0] a_ld;

  // Instance B: 1 channel, LATENCY 1, read-only
  logic        rst_b_n;
  logic        b_rv, b_wv, b_rrdy, b_wrdy;
  logic [7:0]  b_ra, b_wa;
  logic [15:0] b_wd, b_rd;
  logic        b_lv;
  logic [7:0]  b_la;
  logic [15:0] b_ld;

  memory_responder #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(2), .LATENCY(2), .WRITE_ENABLE(1)) dut_a (
    .clk(clk), .reset(rst_a_n),
    .mem_read_valid(a_rv), .mem_read_address(a_ra), .mem_read_ready(a_rrdy), .mem_read_data(a_rd),
    .mem_write_valid(a_wv), .mem_write_address(a_wa), .mem_write_data(a_wd), .mem_write_ready(a_wrdy),
    .load_valid(a_lv), .load_address(a_la), .load_data(a_ld)
  );

  memory_responder #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(1), .LATENCY(1), .WRITE_ENABLE(0)) dut_b (
    .clk(clk), .reset(rst_b_n),
    .mem_read_valid(b_rv), .mem_read_address(b_ra), .mem_read_ready(b_rrdy), .mem_read_data(b_rd),
    .mem_write_valid(b_wv), .mem_write_address(b_wa), .mem_write_data(b_wd), .mem_write_ready(b_wrdy),
    .load_valid(b_lv), .load_address(b_la), .load_data(b_ld)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic a_load(input logic [7:0] addr, input logic [15:0] data);
    @(negedge clk);
    a_lv = 1'b1; a_la = addr; a_ld = data;
    @(negedge clk);
    a_lv = 1'b0;
  endtask

  // One full four-phase transaction on instance A; ready expected LATENCY+1 falling edges after drive.
  task automatic a_txn(input int ch, input bit wr, input logic [7:0] addr,
                       input logic [15:0] wd, input logic [15:0] exp, input string name);
    int   n;
    logic got;
    n = 0; got = 1'b0;
    @(negedge clk);
    if (wr) begin
      a_wv[ch] = 1'b1; a_wa[ch*8 +: 8] = addr; a_wd[ch*16 +: 16] = wd;
    end else begin
      a_rv[ch] = 1'b1; a_ra[ch*8 +: 8] = addr;
    end
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = wr ? a_wrdy[ch] : a_rrdy[ch];
    end
    check({name, " latency"}, n, 3);
    if (!wr) check({name, " data"}, a_rd[ch*16 +: 16], exp);
    if (wr) a_wv[ch] = 1'b0; else a_rv[ch] = 1'b0;
    @(negedge clk);
    check({name, " ready drop"}, wr ? a_wrdy[ch] : a_rrdy[ch], 0);
  endtask

  task automatic b_txn(input bit wr, input logic [7:0] addr, input logic [15:0] wd,
                       input logic [15:0] exp, input string name);
    int   n;
    logic got;
    n = 0; got = 1'b0;
    @(negedge clk);
    if (wr) begin b_wv = 1'b1; b_wa = addr; b_wd = wd; end
    else    begin b_rv = 1'b1; b_ra = addr; end
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = wr ? b_wrdy : b_rrdy;
    end
    check({name, " latency"}, n, 2);
    if (!wr) check({name, " data"}, b_rd, exp);
    if (wr) b_wv = 1'b0; else b_rv = 1'b0;
    @(negedge clk);
    check({name, " ready drop"}, wr ? b_wrdy : b_rrdy, 0);
  endtask

  typedef struct {
    int          ch;
    bit          wr;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
    vecs[1]  = '{0, 1'b1, 8'h20, 16'h1234, 16'h0000};
    vecs[2]  = '{0, 1'b0, 8'h20, 16'h0000, 16'h1234};
    vecs[3]  = '{1, 1'b1, 8'h21, 16'hABCD, 16'h0000};
    vecs[4]  = '{0, 1'b0, 8'h21, 16'h0000, 16'hABCD};
    vecs[5]  = '{1, 1'b0, 8'h20, 16'h0000, 16'h1234};
    vecs[6]  = '{1, 1'b1, 8'hFF, 16'h8001, 16'h0000};
    vecs[7]  = '{1, 1'b0, 8'hFF, 16'h0000, 16'h8001};
    vecs[8]  = '{0, 1'b1, 8'h00, 16'hFFFF, 16'h0000};
    vecs[9]  = '{1, 1'b0, 8'h00, 16'h0000, 16'hFFFF};
    vecs[10] = '{1, 1'b0, 8'h10, 16'h0000, 16'hBEEF};

    rst_a_n = 1'b0; rst_b_n = 1'b0;
    a_rv = '0; a_wv = '0; a_ra = '0; a_wa = '0; a_wd = '0; a_lv = 1'b0; a_la = '0; a_ld = '0;
    b_rv = 1'b0; b_wv = 1'b0; b_ra = '0; b_wa = '0; b_wd = '0; b_lv = 1'b0; b_la = '0; b_ld = '0;

    #1;
    check("reset a_rrdy", a_rrdy, 0);
    check("reset a_wrdy", a_wrdy, 0);
    check("reset a_rd", a_rd, 0);
    check("reset b_rd", b_rd, 0);

    @(negedge clk);
    @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1;

    a_load(8'h10, 16'hBEEF);
    a_load(8'h50, 16'h1111);
    a_load(8'h60, 16'h7777);
    a_load(8'h22, 16'h4444);

    // Read with valid held: ready stays up, data stable, falls one edge after valid drops.
    @(negedge clk);
    a_rv[0] = 1'b1; a_ra[7:0] = 8'h10;
    @(negedge clk);
    check("hold busy1", a_rrdy[0], 0);
    @(negedge clk);
    check("hold busy2", a_rrdy[0], 0);
    @(negedge clk);
    check("hold rise", a_rrdy[0], 1);
    check("hold data", a_rd[15:0], 16'hBEEF);
    @(negedge clk);
    @(negedge clk);
    check("hold still", a_rrdy[0], 1);
    check("hold data stable", a_rd[15:0], 16'hBEEF);
    a_rv[0] = 1'b0;
    @(negedge clk);
    check("hold drop", a_rrdy[0], 0);

    for (int i = 0; i < 11; i++) begin
      a_txn(vecs[i].ch, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].exp,
            $sformatf("vec%0d", i));
    end

    // Both channels write the same address on the same edge: ch0 wins, both acknowledged.
    @(negedge clk);
    a_wv = 2'b11; a_wa = {8'h30, 8'h30}; a_wd = {16'h5555, 16'hAAAA};
    @(negedge clk);
    @(negedge clk);
    check("dual busy", a_wrdy, 2'b00);
    @(negedge clk);
    check("dual ready", a_wrdy, 2'b11);
    a_wv = 2'b00;
    @(negedge clk);
    check("dual drop", a_wrdy, 2'b00);
    a_txn(1, 1'b0, 8'h30, 16'h0, 16'hAAAA, "dual readback");

    // Read and write requested together on one channel: read wins, write never happens.
    @(negedge clk);
    a_rv[0] = 1'b1; a_wv[0] = 1'b1; a_ra[7:0] = 8'h22; a_wa[7:0] = 8'h22; a_wd[15:0] = 16'h9999;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rw rrdy", a_rrdy[0], 1);
    check("rw wrdy", a_wrdy[0], 0);
    check("rw data", a_rd[15:0], 16'h4444);
    a_rv[0] = 1'b0; a_wv[0] = 1'b0;
    @(negedge clk);
    check("rw drop", a_rrdy[0], 0);
    a_txn(0, 1'b0, 8'h22, 16'h0, 16'h4444, "rw readback");

    // Read commit coincides with a side-load of the same address: old value returned.
    @(negedge clk);
    a_rv[0] = 1'b1; a_ra[7:0] = 8'h50;
    @(negedge clk);
    @(negedge clk);
    a_lv = 1'b1; a_la = 8'h50; a_ld = 16'h2222;
    @(negedge clk);
    a_lv = 1'b0;
    check("rd-vs-load ready", a_rrdy[0], 1);
    check("rd-vs-load data", a_rd[15:0], 16'h1111);
    a_rv[0] = 1'b0;
    @(negedge clk);
    a_txn(0, 1'b0, 8'h50, 16'h0, 16'h2222, "after load");

    // Channel write commit coincides with a side-load of the same address: load wins.
    @(negedge clk);
    a_wv[0] = 1'b1; a_wa[7:0] = 8'h31; a_wd[15:0] = 16'h1111;
    @(negedge clk);
    @(negedge clk);
    a_lv = 1'b1; a_la = 8'h31; a_ld = 16'h2222;
    @(negedge clk);
    a_lv = 1'b0;
    check("wr-vs-load ready", a_wrdy[0], 1);
    a_wv[0] = 1'b0;
    @(negedge clk);
    a_txn(1, 1'b0, 8'h31, 16'h0, 16'h2222, "load priority");

    // Reset mid-transaction: ch1 holding a read response, ch0 write to 0x60 just accepted.
    @(negedge clk);
    a_rv[1] = 1'b1; a_ra[15:8] = 8'h10;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre-reset ch1 ready", a_rrdy[1], 1);
    a_wv[0] = 1'b1; a_wa[7:0] = 8'h60; a_wd[15:0] = 16'h9999;
    @(posedge clk);
    #2;
    rst_a_n = 1'b0;
    #1;
    check("async rst rrdy", a_rrdy, 2'b00);
    check("async rst wrdy", a_wrdy, 2'b00);
    check("async rst data", a_rd, 0);
    a_wv = 2'b00; a_rv = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_a_n = 1'b1;
    a_txn(0, 1'b0, 8'h60, 16'h0, 16'h7777, "abandoned write");

    // Read-only instance, LATENCY 1: write acknowledged but array untouched.
    @(negedge clk);
    b_lv = 1'b1; b_la = 8'h40; b_ld = 16'h0F0F;
    @(negedge clk);
    b_lv = 1'b0;
    b_txn(1'b1, 8'h40, 16'hFFFF, 16'h0, "ro write");
    b_txn(1'b0, 8'h40, 16'h0, 16'h0F0F, "ro read");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
# memory_responder

Synthesizable multi-channel global memory model that answers the channel side of the memory controller's read/write valid/ready protocol. Each channel independently accepts one request and responds after a fixed latency, holding `ready` until the controller drops `valid` (four-phase handshake). It backs both data memory (`WRITE_ENABLE=1`) and read-only program memory, and carries a side-load port for test and boot images.

## Interface
- `ADDR_BITS`, 8: address width; array depth is 2^ADDR_BITS words.
- `DATA_BITS`, 16: word width.
- `NUM_CHANNELS`, 1: number of independent request channels.
- `LATENCY`, 2: cycles from request acceptance to `ready` assertion; legal range is 1..15.
- `WRITE_ENABLE`, 1: when 0, channel write requests still complete but do not modify the array.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`, in, 1: clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low. Asserted at 0; deassertion is synchronous to `clk`.
- `mem_read_valid`, in, NUM_CHANNELS: per-channel read request.
- `mem_read_address`, in, ADDR_BITS × NUM_CHANNELS: read address per channel.
- `mem_read_ready`, out, NUM_CHANNELS: read data valid; held high until `valid` is seen low.
- `mem_read_data`, out, DATA_BITS × NUM_CHANNELS: read data, stable while `ready` is high.
- `mem_write_valid`, in, NUM_CHANNELS: per-channel write request.
- `mem_write_address`, in, ADDR_BITS × NUM_CHANNELS: write address per channel.
- `mem_write_data`, in, DATA_BITS × NUM_CHANNELS: write data per channel.
- `mem_write_ready`, out, NUM_CHANNELS: write-complete acknowledge.
- `load_valid`, in, 1: side-load write strobe.
- `load_address`, in, ADDR_BITS: side-load address.
- `load_data`, in, DATA_BITS: side-load data.

## Operation
- Per-channel FSM with states IDLE, BUSY and RESPOND.
- IDLE:
  - If `mem_read_valid[i]` is high: latch the address, set kind to read, load the counter with `LATENCY-1`, go to BUSY.
  - Else if `mem_write_valid[i]` is high: latch address and data, set kind to write, load the counter, go to BUSY.
  - If both are high, read wins.
- BUSY:
  - Counter nonzero: decrement.
  - Counter zero (commit edge): go to RESPOND.
    - Read: capture `array[addr]` into `mem_read_data[i]` and set `mem_read_ready[i]`.
    - Write: issue the array write and set `mem_write_ready[i]`.
- RESPOND: when the valid of the latched kind is sampled low, clear the corresponding ready and go to IDLE.
- The latched address and data are used for the whole transaction. Input changes during BUSY or RESPOND are ignored.
- Array writes:
  - At most one write per address per edge.
  - Priority: `load_valid` first, then lowest channel index.
  - Losing channel writes to the same address are dropped, but those channels still get `ready`.
  - Writes to different addresses on the same edge all commit.
  - `load_valid` writes regardless of `WRITE_ENABLE` and regardless of channel state.
- Read vs. write on the same edge: a read commit returns the array value from before that edge's writes.
- Array contents are not reset. After reset they are undefined until loaded; the bench must preload.

## Timing
- Reset values (asynchronous): all `mem_read_ready`, `mem_write_ready` and `mem_read_data` are 0; every FSM is in IDLE; all counters are 0.
- Request sampled at edge T:
  - `ready` rises at edge T+LATENCY.
  - For LATENCY=1, `ready` rises on the next edge.
- The controller drops `valid` at the edge where it sees `ready`, i.e. T+LATENCY+1.
  - The responder samples `valid` low at T+LATENCY+2 and drops `ready` there.
  - The channel is back in IDLE at T+LATENCY+2 and can accept a new `valid` at the following edge.
- `ready` is never asserted in IDLE or BUSY. `mem_read_data` changes only on a read commit edge.
- Channels are fully independent; there is no cross-channel stall.
- Reset asserted mid-transaction:
  - Outstanding requests are abandoned and `ready` drops immediately.
  - A write whose commit edge has not occurred is not performed.

## Test plan
- Preload `load`: addr 0x10 = 0xBEEF. Channel 0 reads 0x10 with LATENCY=2 -> `mem_read_ready[0]` rises exactly 2 edges after sampling with data 0xBEEF; it stays high until `valid` drops, then falls one edge later.
- Channel 0 writes 0x20 = 0x1234, then reads 0x20 -> write ready after 2 cycles; read returns 0x1234.
- NUM_CHANNELS=2: both channels write 0x30 on the same cycle with 0xAAAA (ch0) and 0x5555 (ch1) -> both readies assert; a later read of 0x30 returns 0xAAAA.
- `WRITE_ENABLE=0`: preload 0x40 = 0x0F0F; channel write 0x40 = 0xFFFF -> ready asserts; a read returns 0x0F0F.
- Read 0x50 (old 0x1111) commits on the same edge as a `load` of 0x50 = 0x2222 -> read returns 0x1111; the next read returns 0x2222.
- `reset` pulled low during BUSY of a write to 0x60 (old 0x7777) -> readies go to 0 asynchronously; after release, a read of 0x60 returns 0x7777.
